// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    // Operation sequencer: wait for operands, shift one bit per cycle, hold result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Default operand width and the matching bit-counter width.
    localparam int SER_WIDTH = 4;
    localparam int CNT_W     = $clog2(SER_WIDTH);

    // Counter width for an arbitrary operand width (never below one bit).
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_bit_cell.sv
// One-bit full-adder cell; inv_b turns it into a subtract cell (a + ~b + cin).
module serial_bit_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic cin,
    input  logic inv_b,
    output logic s,
    output logic cout
);

    logic bb;

    // Sum and majority carry of a, optionally inverted b, and carry-in.
    always_comb begin
        bb   = b_bit ^ inv_b;
        s    = a_bit ^ bb ^ cin;
        cout = (a_bit & bb) | (a_bit & cin) | (bb & cin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first,
// WIDTH cycles per operation, valid/ready on both sides.
// Optional macro SERIAL_SUBTRACTOR_ADD_MODE_EN adds an add_mode input that
// switches the operation to a + b + bin.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    input  logic             add_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b, diff_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sub_q;     // 1 = subtract (b inverted), 0 = add
    logic             bout_q, ovf_q;
    logic             accept, last;
    logic             cell_s, cell_cout;
    logic             add_in;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    assign add_in = add_mode;
`else
    assign add_in = 1'b0;
`endif

    assign accept = in_valid && in_ready;
    assign last   = (state == SHIFT) && (cnt == LAST);

    serial_bit_cell u_cell (
        .a_bit (sh_a[0]),
        .b_bit (sh_b[0]),
        .cin   (carry),
        .inv_b (sub_q),
        .s     (cell_s),
        .cout  (cell_cout)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, serial datapath and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a   <= '0;
            sh_b   <= '0;
            diff_q <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sub_q  <= 1'b1;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            sh_a   <= a;
            sh_b   <= b;
            sub_q  <= ~add_in;
            // Subtract seeds the carry with ~bin so a + ~b + ~bin = a - b - bin.
            carry  <= add_in ? bin : ~bin;
            diff_q <= '0;
            cnt    <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state == SHIFT) begin
            diff_q <= {cell_s, diff_q[WIDTH-1:1]};
            sh_a   <= sh_a >> 1;
            sh_b   <= sh_b >> 1;
            carry  <= cell_cout;
            cnt    <= cnt + 1'b1;
            if (last) begin
                // sh_a[0]/sh_b[0] hold the latched operand sign bits here,
                // and cell_s is the result sign bit.
                bout_q <= sub_q ? ~cell_cout : cell_cout;
                ovf_q  <= ((sh_a[0] ^ sh_b[0]) == sub_q) && (cell_s != sh_a[0]);
            end
        end
    end

    assign diff     = diff_q;
    assign bout     = bout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, corner
// sequences, and random (or exhaustive in add-mode builds) operations
// compared against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0, b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout, overflow;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    logic         add_mode = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        .add_mode  (add_mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .overflow  (overflow)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input int ai, input int bi, input int ci, input bit add,
                         output int d, output int bo, output int ov);
        int r, am, bm, dm;
        if (add) begin
            r  = ai + bi + ci;
            bo = (r >= (1 << W)) ? 1 : 0;
        end else begin
            r  = ai - bi - ci;
            bo = (ai < bi + ci) ? 1 : 0;
        end
        d  = r & ((1 << W) - 1);
        am = (ai >> (W - 1)) & 1;
        bm = (bi >> (W - 1)) & 1;
        dm = (d  >> (W - 1)) & 1;
        if (add) ov = (am == bm && dm != am) ? 1 : 0;
        else     ov = (am != bm && dm != am) ? 1 : 0;
    endtask

    // Issue one operation and wait for the result; leaves the DUT in DONE.
    task automatic start_op(input int ai, input int bi, input int ci, input bit add,
                            output bit ok);
        int n;
        ok = 1'b0;
        a = W'(ai); b = W'(bi); bin = ci[0];
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        add_mode = add;
`endif
        in_valid = 1'b1;
        chk("in_ready_idle", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble inputs: they must be ignored after the accepting edge.
        a = W'($urandom); b = W'($urandom); bin = $urandom_range(0, 1);
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        add_mode = $urandom_range(0, 1);
`endif
        chk("in_ready_shift", int'(in_ready), 0);
        for (n = 1; n <= W + 3; n++) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        chk("latency", n, W);
        ok = out_valid;
    endtask

    task automatic release_op();
        logic [W-1:0] d0;
        d0 = diff;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_accept", int'(out_valid), 0);
        chk("in_ready_after_accept", int'(in_ready), 1);
        chk("diff_held_after_accept", int'(diff), int'(d0));
    endtask

    task automatic run_check(input int ai, input int bi, input int ci, input bit add,
                             input bit full);
        int  d, bo, ov;
        bit  ok;
        model(ai, bi, ci, add, d, bo, ov);
        start_op(ai, bi, ci, add, ok);
        if (!ok) begin
            chk("result_timeout", 0, 1);
        end else if (full) begin
            chk("diff", int'(diff), d);
            chk("bout", int'(bout), bo);
            chk("overflow", int'(overflow), ov);
        end else begin
            // Quiet form for large sweeps: one combined comparison per op.
            checks++;
            if (int'(diff) != d || int'(bout) != bo || int'(overflow) != ov) begin
                errors++;
                $display("FAIL sweep a=%0d b=%0d bin=%0d add=%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         ai, bi, ci, add, diff, bout, overflow, d, bo, ov);
            end
        end
        release_op();
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        bit   ok;
        logic [W-1:0] d0;
        logic         bo0, ov0;

        vecs.push_back('{4'h7, 4'h3, 1'b0, 4'h4, 1'b0, 1'b0});
        vecs.push_back('{4'h3, 4'h5, 1'b0, 4'hE, 1'b1, 1'b0});
        vecs.push_back('{4'h5, 4'h2, 1'b1, 4'h2, 1'b0, 1'b0});
        vecs.push_back('{4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1});
        vecs.push_back('{4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1});
        vecs.push_back('{4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0});
        vecs.push_back('{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0});
        vecs.push_back('{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0});

        // Reset state.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_bout", int'(bout), 0);
        chk("rst_overflow", int'(overflow), 0);

        // Directed table.
        foreach (vecs[i]) begin
            v = vecs[i];
            start_op(int'(v.a), int'(v.b), int'(v.bin), 1'b0, ok);
            chk("tbl_valid", int'(ok), 1);
            chk("tbl_diff", int'(diff), int'(v.d));
            chk("tbl_bout", int'(bout), int'(v.bo));
            chk("tbl_overflow", int'(overflow), int'(v.ov));
            release_op();
        end

        // Backpressure: result held for 3 cycles while inputs churn.
        start_op(3, 5, 0, 1'b0, ok);
        chk("bp_valid", int'(ok), 1);
        d0 = diff; bo0 = bout; ov0 = overflow;
        for (int k = 0; k < 3; k++) begin
            a = W'($urandom); b = W'($urandom);
            in_valid = k[0];
            @(posedge clk); #1;
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_diff", int'(diff), int'(d0));
            chk("bp_bout", int'(bout), int'(bo0));
            chk("bp_overflow", int'(overflow), int'(ov0));
        end
        release_op();

        // Reset on the second SHIFT edge aborts the operation.
        a = 4'h7; b = 4'h3; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_diff", int'(diff), 0);
        chk("abort_bout", int'(bout), 0);
        repeat (W + 1) begin
            @(posedge clk); #1;
            chk("abort_no_valid", int'(out_valid), 0);
        end
        run_check(5, 2, 1, 1'b0, 1'b1);

        // Random subtractions.
        for (int k = 0; k < 40; k++)
            run_check(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 1)), 1'b0, 1'b0);

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        run_check(9, 8, 0, 1'b1, 1'b1);
        chk("add_9_8_diff", int'(diff), 1);
        chk("add_9_8_bout", int'(bout), 1);
        for (int m = 0; m < 2; m++)
            for (int ai = 0; ai < 16; ai++)
                for (int bi = 0; bi < 16; bi++)
                    for (int ci = 0; ci < 2; ci++)
                        run_check(ai, bi, ci, m[0], 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
